// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared encodings and constants for the multiply/divide unit
package mdu_pkg;

    localparam int WIDTH_DEF = 32;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam logic [WIDTH_DEF-1:0] DIV0_QUOT = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DFIX
    } state_e;

endpackage

// File: rtl/div_core.sv
// rtl/div_core.sv - iterative unsigned restoring divider, one quotient bit per step
module div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem
);

    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic [WIDTH:0]   r_sh, diff;

    // quo_q starts as the dividend and shifts quotient bits in from the right
    assign r_sh = {rem_q, quo_q[WIDTH-1]};
    assign diff = r_sh - {1'b0, dvs_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
        end else if (step) begin
            if (!diff[WIDTH]) begin
                rem_q <= diff[WIDTH-1:0];
                quo_q <= {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_q <= r_sh[WIDTH-1:0];
                quo_q <= {quo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign quot = quo_q;
    assign rem  = rem_q;

endmodule

// File: rtl/mdu_hilo.sv
// rtl/mdu_hilo.sv - multi-cycle MULT/DIV unit owning the architectural HI/LO registers
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int MUL_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             flush,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CMAX = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
    localparam int CW   = $clog2(CMAX) + 1;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] ma_q, mb_q, dsa_q;
    logic             msgn_q, qneg_q, rneg_q, dz_q;
    logic             mul_load, div_load, div_step;

    logic             sdiv, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag, quot, rem;
    logic [2*WIDTH-1:0] ea, eb, prod;

    assign sdiv  = (op == OP_DIV);
    assign a_neg = sdiv & srca[WIDTH-1];
    assign b_neg = sdiv & srcb[WIDTH-1];
    assign a_mag = a_neg ? (~srca + 1'b1) : srca;
    assign b_mag = b_neg ? (~srcb + 1'b1) : srcb;

    // sign- or zero-extend to 2*WIDTH so one multiplier serves MULT and MULTU
    assign ea   = msgn_q ? {{WIDTH{ma_q[WIDTH-1]}}, ma_q} : {{WIDTH{1'b0}}, ma_q};
    assign eb   = msgn_q ? {{WIDTH{mb_q[WIDTH-1]}}, mb_q} : {{WIDTH{1'b0}}, mb_q};
    assign prod = ea * eb;

    div_core #(.WIDTH(WIDTH)) u_div (
        .clk      (clk),
        .rst      (rst),
        .load     (div_load),
        .step     (div_step),
        .dividend (a_mag),
        .divisor  (b_mag),
        .quot     (quot),
        .rem      (rem)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        mul_load = 1'b0;
        div_load = 1'b0;
        div_step = 1'b0;
        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                mul_load = 1'b1;
                                state_d  = ST_MUL;
                                cnt_d    = CW'(MUL_CYCLES - 1);
                            end
                            OP_DIV, OP_DIVU: begin
                                div_load = 1'b1;
                                state_d  = ST_DIV;
                                cnt_d    = CW'(WIDTH - 1);
                            end
                            OP_MTHI: hi_d = srca;
                            OP_MTLO: lo_d = srca;
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    if (cnt_q == '0) begin
                        {hi_d, lo_d} = prod;
                        state_d      = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_DIV: begin
                    div_step = 1'b1;
                    if (cnt_q == '0) state_d = ST_DFIX;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                ST_DFIX: begin
                    // divide-by-zero result is fixed regardless of operand signs
                    if (dz_q) begin
                        lo_d = WIDTH'(DIV0_QUOT);
                        hi_d = dsa_q;
                    end else begin
                        lo_d = qneg_q ? (~quot + 1'b1) : quot;
                        hi_d = rneg_q ? (~rem + 1'b1) : rem;
                    end
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            ma_q    <= '0;
            mb_q    <= '0;
            msgn_q  <= 1'b0;
            dsa_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            if (mul_load) begin
                ma_q   <= srca;
                mb_q   <= srcb;
                msgn_q <= (op == OP_MULT);
            end
            if (div_load) begin
                dsa_q  <= srca;
                qneg_q <= a_neg ^ b_neg;
                rneg_q <= a_neg;
                dz_q   <= (srcb == '0);
            end
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// tb/tb_mdu_hilo.sv - directed scoreboard bench for mdu_hilo
`timescale 1ns/1ps
module tb_mdu_hilo;

    logic        clk = 1'b0;
    logic        rst, start, flush, busy;
    logic [2:0]  op;
    logic [31:0] srca, srcb, hi, lo;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [7:0]  cyc;
    } exp_t;

    exp_t sbq[$];

    mdu_hilo #(.WIDTH(32), .MUL_CYCLES(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .srca  (srca),
        .srcb  (srcb),
        .flush (flush),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        op    = o;
        srca  = a;
        srcb  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input int ecyc);
        exp_t e;
        int   n;
        sbq.push_back('{hi: eh, lo: el, cyc: 8'(ecyc)});
        issue(o, a, b);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        e = sbq.pop_front();
        chk($sformatf("%s_cycles", tag), 32'(n), 32'(e.cyc));
        chk($sformatf("%s_hi", tag), hi, e.hi);
        chk($sformatf("%s_lo", tag), lo, e.lo);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'b000; srca = '0; srcb = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_hi", hi, 32'h0);
        chk("reset_lo", lo, 32'h0);

        run_op("mult_neg", 3'b000, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 4);
        run_op("multu_max", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 4);
        run_op("mult_b2b", 3'b000, 32'd6, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'hFFFFFFD6, 4);
        run_op("div_m7_2", 3'b010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
        run_op("div_ovf", 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 33);
        run_op("divu_100_7", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 33);
        run_op("div_7_m2", 3'b010, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 33);
        run_op("divu_by0", 3'b011, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFF, 33);
        run_op("div_by0_neg", 3'b010, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 33);

        issue(3'b100, 32'hAAAA0000, 32'd0);
        chk("mthi_busy", {31'b0, busy}, 32'd0);
        chk("mthi_hi", hi, 32'hAAAA0000);
        chk("mthi_lo_kept", lo, 32'hFFFFFFFF);
        issue(3'b101, 32'h00005555, 32'd0);
        chk("mtlo_hi_kept", hi, 32'hAAAA0000);
        chk("mtlo_lo", lo, 32'h00005555);

        issue(3'b010, 32'd100, 32'd3);
        repeat (9) tick();
        chk("flush_pre_busy", {31'b0, busy}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_busy", {31'b0, busy}, 32'd0);
        chk("flush_hi", hi, 32'hAAAA0000);
        chk("flush_lo", lo, 32'h00005555);
        repeat (30) tick();
        chk("flush_late_hi", hi, 32'hAAAA0000);
        chk("flush_late_lo", lo, 32'h00005555);

        issue(3'b010, 32'd100, 32'd3);
        repeat (4) tick();
        issue(3'b100, 32'h00000999, 32'd0);
        chk("ign_mthi_busy", {31'b0, busy}, 32'd1);
        chk("ign_mthi_hi", hi, 32'hAAAA0000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_hi", hi, 32'h0);
        chk("midrst_lo", lo, 32'h0);
        issue(3'b100, 32'h00000001, 32'd0);
        chk("post_rst_mthi_hi", hi, 32'h1);
        chk("post_rst_mthi_lo", lo, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
Multi-cycle multiply/divide unit in the EX stage of the 5-stage pipelined MIPS CPU. It consumes the two register-file read operands after ID/EX and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. It owns the architectural HI/LO registers, which MFHI/MFLO read directly. The hazard unit uses busy to stall the pipeline.

Parameters:
WIDTH, 32, operand and HI/LO width
MUL_CYCLES, 4, cycles busy for MULT/MULTU (must be >= 1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset: synchronous, active-high; one clock; all state on clk
start  in  1  issue request, sampled at clk edge
op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op
srca  in  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data)
srcb  in  WIDTH  rt operand (divisor / multiplier)
flush  in  1  cancel in-flight operation (branch/exception squash)
busy  out  1  high while an operation is in flight
hi  out  WIDTH  architectural HI register
lo  out  WIDTH  architectural LO register

Behaviour:
- Reset: at any clk edge with rst=1, state goes to IDLE, counter=0, hi=0, lo=0, busy=0. Reset overrides flush, start and completion, including mid-operation.
- States: IDLE, MUL, DIV, DFIX. busy = (state != IDLE), decoded from registered state only.
- Priority at each edge: rst > flush > completion > start.
- start is accepted only in IDLE. A start while busy is ignored; the hazard unit must hold the instruction.
- MTHI/MTLO at edge t: hi (or lo) <= srca at edge t. No busy. The other register is unchanged.
- MULT/MULTU at edge t: latch operands, counter <= MUL_CYCLES-1, state goes to MUL.
  - Each MUL edge with counter != 0 decrements the counter.
  - At the edge with counter == 0: {hi,lo} <= 64-bit product (signed or unsigned) and state goes to IDLE.
  - busy is high for exactly MUL_CYCLES cycles after the start edge.
  - Internal implementation (single multiply plus hold, or iterative) is free, provided latency is exact.
- DIV/DIVU at edge t: latch operands. Record quotient sign = sa^sb and remainder sign = sa (signed only). Load magnitudes into the restoring divider, counter <= WIDTH-1, state goes to DIV.
  - One quotient bit per DIV edge. After WIDTH iterations, state goes to DFIX.
  - DFIX edge: apply sign fixup, lo <= quotient, hi <= remainder, state goes to IDLE.
  - busy is high for WIDTH+1 cycles (33 at default).
- Division rules: quotient truncates toward zero; remainder takes the sign of the dividend.
- Divide by zero: full latency still applies. Result lo = all ones, hi = srca, for both signed and unsigned.
- Signed overflow (0x80000000 / -1): lo = 0x80000000, hi = 0.
- hi/lo change only on a completion edge or an MTHI/MTLO edge. They are never partially updated.
- flush=1 at an edge: state goes to IDLE, counter is cleared, hi/lo are unchanged, and any start on that edge is dropped. flush while IDLE has no effect.
- A start is legal on the first cycle busy=0 after completion. There is no bypass of in-flight results; MFHI while busy must be stalled by the hazard unit.

Decomposition:
- mdu_pkg holds:
  - op encodings (OP_MULT .. OP_MTLO)
  - state enum (IDLE, MUL, DIV, DFIX)
  - WIDTH default
  - DIV0_QUOT constant (all ones)
- Sub-module div_core: iterative unsigned restoring divider (load, step, quotient/remainder out).
  - mdu_hilo handles sign magnitude conversion and fixup, the MUL path, the FSM and HI/LO.

Test Plan:
- rst, then MULT srca=0xFFFFFFFD srcb=7 -> busy high 4 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 4 cycles; back-to-back start on first busy=0 cycle is accepted.
- Signed and unsigned division:
  - DIV -7/2 -> busy 33 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
  - DIVU 100/7 -> lo=14, hi=2.
- DIVU 0x1234/0 -> after 33 cycles lo=0xFFFFFFFF, hi=0x1234.
- Preload MTHI 0xAAAA0000 and MTLO 0x5555; start DIV and assert flush on the 10th busy cycle -> busy low next cycle, hi/lo keep the preloaded values.
- Start DIV; at cycle 5 start MTHI (ignored); then assert rst mid-divide -> next cycle busy=0, hi=0, lo=0; MTHI 0x1 after reset gives hi=1.
